pc_sequencer: RTL

Program-counter sequencer for the 141L core: holds the architectural PC, drives the index input of the absolute-jump lookup table and consumes its combinational target. It handles program start, sequential fetch, absolute jumps, signed relative branches, stalls and halt, and signals run/done status to the testbench.

---
 rtl/pc_pkg.sv | 7 +
 rtl/pc_sequencer_ret_stack.sv | 44 ++++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package pc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int PC_W          = 12;
  localparam int STACK_DEPTH_D = 4;
  localparam int LUT_W         = 8;
endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: synchronous push/pop/clear, top-of-stack visible combinationally.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] top_idx;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_idx = AW'(cnt - CW'(1));
  assign pop_dat = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Entries need no reset; the count alone defines which ones are valid.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[AW'(cnt)] <= push_dat;
  end
endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: start, increment, absolute/relative jumps, stall, halt, run/done status.
// Optional return stack for Call/Ret enabled by defining CALL_STACK_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D           = PC_W,
  parameter int STACK_DEPTH = STACK_DEPTH_D
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [LUT_W-1:0] ProgSel,
  output logic [LUT_W-1:0] LutAddr,
  input  logic [D-1:0]     LutTarget,
  input  logic             AbsJump,
  input  logic             RelBranch,
  input  logic             Taken,
  input  logic [LUT_W-1:0] JumpIdx,
  input  logic [LUT_W-1:0] Offset,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             Call,
  input  logic             Ret,
  output logic [D-1:0]     ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             StackErr
);
  state_t       state;
  logic [D-1:0] pc_inc;
  logic [D-1:0] pc_rel;

  assign LutAddr = (state == RUN) ? JumpIdx : ProgSel;
  assign pc_inc  = ProgCtr + D'(1);
  assign pc_rel  = ProgCtr + {{(D-LUT_W){Offset[LUT_W-1]}}, Offset};

`ifdef CALL_STACK_EN
  logic         ctl_ok;
  logic         stk_push;
  logic         stk_pop;
  logic         stk_clear;
  logic         stk_full;
  logic         stk_empty;
  logic [D-1:0] stk_top;
  logic         stack_err;

  // Ret outranks Call, and both sit below Stall and Halt.
  assign ctl_ok    = (state == RUN) && !Stall && !Halt;
  assign stk_pop   = ctl_ok && Ret;
  assign stk_push  = ctl_ok && Call && !Ret;
  assign stk_clear = (state != RUN) && Start;
  assign StackErr  = stack_err;

  ret_stack #(.DEPTH(STACK_DEPTH), .W(D)) u_ret_stack (
    .clk      (Clk),
    .rst      (Reset),
    .clear    (stk_clear),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_dat (pc_inc),
    .pop_dat  (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );
`else
  logic unused_ctrl;
  assign unused_ctrl = Call ^ Ret ^ (STACK_DEPTH == 0);
  assign StackErr    = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
`ifdef CALL_STACK_EN
      stack_err <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (Stall) begin
            state <= RUN;
          end else if (Halt) begin
            state   <= DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
`ifdef CALL_STACK_EN
          end else if (Ret) begin
            if (stk_empty) begin
              ProgCtr   <= pc_inc;
              stack_err <= 1'b1;
            end else begin
              ProgCtr <= stk_top;
            end
          end else if (Call) begin
            ProgCtr <= LutTarget;
            if (stk_full) stack_err <= 1'b1;
`endif
          end else if (AbsJump && Taken) begin
            ProgCtr <= LutTarget;
          end else if (RelBranch && Taken) begin
            ProgCtr <= pc_rel;
          end else begin
            ProgCtr <= pc_inc;
          end
        end
        default: begin
          if (Start) begin
            state   <= RUN;
            ProgCtr <= LutTarget;
            Running <= 1'b1;
            Done    <= 1'b0;
`ifdef CALL_STACK_EN
            stack_err <= 1'b0;
`endif
          end
        end
      endcase
    end
  end
endmodule
